// File: rtl/measure_pkg.sv
// Shared types and default widths for the frequency-measurement run-control sequencer.
package measure_pkg;

  localparam int DEF_GATE_W = 32;
  localparam int DEF_AVG_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_OUT
  } state_e;

  // One core result as it appears on the measurement data bus.
  typedef struct packed {
    logic [DEF_GATE_W-1:0] ref_cnt;
    logic [DEF_GATE_W-1:0] sig_cnt;
  } meas_data_t;

endpackage

// File: rtl/measure_acc.sv
// Dual {ref,sig} accumulator with a result counter; flags the result that completes an average.
module measure_acc
  import measure_pkg::*;
#(
  parameter int GATE_W = DEF_GATE_W,
  parameter int AVG_W  = DEF_AVG_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      add_i,
  input  logic [AVG_W-1:0]          avg_num_i,
  input  logic [2*GATE_W-1:0]       data_i,
  output logic [GATE_W+AVG_W-1:0]   acc_sig_o,
  output logic [GATE_W+AVG_W-1:0]   acc_ref_o,
  output logic                      last_o
);

  localparam int ACC_W = GATE_W + AVG_W;

  logic [ACC_W-1:0] acc_sig_q;
  logic [ACC_W-1:0] acc_ref_q;
  logic [AVG_W-1:0] cnt_q;
  logic [AVG_W:0]   target;

  // An average count of zero behaves as one.
  assign target = (avg_num_i == '0) ? (AVG_W+1)'(1) : {1'b0, avg_num_i};
  assign last_o = ({1'b0, cnt_q} + (AVG_W+1)'(1)) == target;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_sig_q <= '0;
      acc_ref_q <= '0;
      cnt_q     <= '0;
    end else if (add_i) begin
      acc_sig_q <= acc_sig_q + ACC_W'(data_i[GATE_W-1:0]);
      acc_ref_q <= acc_ref_q + ACC_W'(data_i[2*GATE_W-1:GATE_W]);
      cnt_q     <= cnt_q + AVG_W'(1);
    end
  end

  assign acc_sig_o = acc_sig_q;
  assign acc_ref_o = acc_ref_q;

endmodule

// File: rtl/measure_ctrl.sv
// Run-control sequencer: arms the measure core, averages N results, applies a per-result
// timeout and hands the summed {ref,sig} downstream on a valid/ready interface.
module measure_ctrl
  import measure_pkg::*;
#(
  parameter int GATE_W = DEF_GATE_W,
  parameter int AVG_W  = DEF_AVG_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_start_i,
  input  logic                    cmd_stop_i,
  input  logic                    cfg_cont_i,
  input  logic [GATE_W-1:0]       cfg_gate_time_i,
  input  logic [AVG_W-1:0]        cfg_avg_num_i,
  input  logic [GATE_W-1:0]       cfg_timeout_i,
  output logic                    meas_run_o,
  output logic [GATE_W-1:0]       meas_gate_time_o,
  input  logic                    meas_done_i,
  input  logic [2*GATE_W-1:0]     meas_data_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [GATE_W+AVG_W-1:0] res_sig_o,
  output logic [GATE_W+AVG_W-1:0] res_ref_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  gate_q;
  logic [GATE_W-1:0]  tmo_q;
  logic [GATE_W-1:0]  wait_cnt_q;
  logic [GATE_W-1:0]  gate_out_q;
  logic [AVG_W-1:0]   avg_q;
  logic               cont_q;
  logic               stop_q;
  logic               timeout_q;

  logic latch_cfg;
  logic acc_clr;
  logic acc_add;
  logic acc_last;
  logic tmo_hit;
  logic tmo_fire;

  assign tmo_hit = (tmo_q != '0) && (wait_cnt_q == tmo_q);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    tmo_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start_i) begin
          latch_cfg = 1'b1;
          acc_clr   = 1'b1;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: state_d = ST_WAIT;
      ST_WAIT: begin
        // A result arriving on the timeout cycle takes precedence over the timeout.
        if (meas_done_i) begin
          acc_add = 1'b1;
          if (acc_last) state_d = ST_OUT;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          acc_clr  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (res_ready_i) begin
          if (cont_q && !stop_q && !cmd_stop_i) begin
            acc_clr = 1'b1;
            state_d = ST_ARM;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gate_q     <= '0;
      tmo_q      <= '0;
      avg_q      <= '0;
      cont_q     <= 1'b0;
      stop_q     <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
      gate_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_cfg) begin
        gate_q <= cfg_gate_time_i;
        tmo_q  <= cfg_timeout_i;
        avg_q  <= cfg_avg_num_i;
        cont_q <= cfg_cont_i;
      end
      if (latch_cfg)     timeout_q <= 1'b0;
      else if (tmo_fire) timeout_q <= 1'b1;
      if (state_q == ST_ARM) begin
        gate_out_q <= gate_q;
        wait_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wait_cnt_q <= meas_done_i ? '0 : wait_cnt_q + GATE_W'(1);
      end
      if (state_d == ST_IDLE)                     stop_q <= 1'b0;
      else if (cmd_stop_i && state_q != ST_IDLE) stop_q <= 1'b1;
    end
  end

  measure_acc #(
    .GATE_W (GATE_W),
    .AVG_W  (AVG_W)
  ) u_acc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (acc_clr),
    .add_i     (acc_add),
    .avg_num_i (avg_q),
    .data_i    (meas_data_i),
    .acc_sig_o (res_sig_o),
    .acc_ref_o (res_ref_o),
    .last_o    (acc_last)
  );

  assign meas_run_o       = (state_q == ST_WAIT);
  assign meas_gate_time_o = gate_out_q;
  assign res_valid_o      = (state_q == ST_OUT);
  assign busy_o           = (state_q != ST_IDLE);
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_measure_ctrl.sv
// Directed-plus-random bench for measure_ctrl; expected sums come from queues of issued results.
module tb_measure_ctrl;
  import measure_pkg::*;

  localparam int GATE_W = DEF_GATE_W;
  localparam int AVG_W  = DEF_AVG_W;
  localparam int ACC_W  = GATE_W + AVG_W;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              cmd_start_i = 1'b0;
  logic              cmd_stop_i = 1'b0;
  logic              cfg_cont_i = 1'b0;
  logic [GATE_W-1:0] cfg_gate_time_i = '0;
  logic [AVG_W-1:0]  cfg_avg_num_i = '0;
  logic [GATE_W-1:0] cfg_timeout_i = '0;
  logic              meas_run_o;
  logic [GATE_W-1:0] meas_gate_time_o;
  logic              meas_done_i = 1'b0;
  logic [2*GATE_W-1:0] meas_data_i = '0;
  logic              res_valid_o;
  logic              res_ready_i = 1'b0;
  logic [ACC_W-1:0]  res_sig_o;
  logic [ACC_W-1:0]  res_ref_o;
  logic              busy_o;
  logic              timeout_o;

  measure_ctrl #(.GATE_W(GATE_W), .AVG_W(AVG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_start_i(cmd_start_i), .cmd_stop_i(cmd_stop_i),
    .cfg_cont_i(cfg_cont_i), .cfg_gate_time_i(cfg_gate_time_i), .cfg_avg_num_i(cfg_avg_num_i),
    .cfg_timeout_i(cfg_timeout_i), .meas_run_o(meas_run_o), .meas_gate_time_o(meas_gate_time_o),
    .meas_done_i(meas_done_i), .meas_data_i(meas_data_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_sig_o(res_sig_o), .res_ref_o(res_ref_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [GATE_W-1:0] q_sig[$];
  logic [GATE_W-1:0] q_ref[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic deliver(input logic [GATE_W-1:0] r, input logic [GATE_W-1:0] s);
    meas_data_t d;
    d.ref_cnt   = r;
    d.sig_cnt   = s;
    meas_done_i = 1'b1;
    meas_data_i = d;
    tick();
    meas_done_i = 1'b0;
    meas_data_i = {$urandom, $urandom};
  endtask

  // Starts a run, checks arm latency and gate, then scrambles cfg to prove it was latched.
  task automatic start_run(input logic cont, input int gate, input int avg, input int tmo);
    cfg_cont_i      = cont;
    cfg_gate_time_i = gate;
    cfg_avg_num_i   = avg[AVG_W-1:0];
    cfg_timeout_i   = tmo;
    cmd_start_i     = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    check("arm_busy", busy_o, 1);
    check("arm_run_low", meas_run_o, 0);
    check("start_clears_timeout", timeout_o, 0);
    cfg_gate_time_i = $urandom;
    cfg_avg_num_i   = AVG_W'($urandom);
    cfg_timeout_i   = $urandom_range(1, 3);
    cfg_cont_i      = ~cont;
    tick();
    check("run_latency", meas_run_o, 1);
    check("gate_out", meas_gate_time_o, gate);
  endtask

  // Delivers n queued results with random gaps; the final one must produce the summed output.
  task automatic run_batch(input int n, input int max_gap);
    logic [63:0] es;
    logic [63:0] er;
    logic [GATE_W-1:0] s;
    logic [GATE_W-1:0] r;
    es = '0;
    er = '0;
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, max_gap));
      s  = q_sig.pop_front();
      r  = q_ref.pop_front();
      es = es + 64'(s);
      er = er + 64'(r);
      deliver(r, s);
      if (i < n - 1) begin
        check("mid_valid_low", res_valid_o, 0);
        check("mid_run_high", meas_run_o, 1);
      end
    end
    check("res_valid", res_valid_o, 1);
    check("res_run_low", meas_run_o, 0);
    check("res_sig", res_sig_o, es);
    check("res_ref", res_ref_o, er);
  endtask

  task automatic accept();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      q_sig.push_back($urandom);
      q_ref.push_back($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACC_W-1:0] held_sig;
    logic [ACC_W-1:0] held_ref;
    bit bad_run;
    bit bad_data;
    bit seen_valid;
    int n_avg;

    tick(3);
    check("rst_busy", busy_o, 0);
    check("rst_run", meas_run_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_sig", res_sig_o, 0);
    check("rst_gate", meas_gate_time_o, 0);
    rst_i = 1'b0;
    tick();

    // Done and stop while idle are ignored.
    deliver(7, 7);
    cmd_stop_i = 1'b1;
    tick();
    cmd_stop_i = 1'b0;
    check("idle_done_busy", busy_o, 0);
    check("idle_done_valid", res_valid_o, 0);

    // Single shot, avg=1, gate=1000, core answers ~1005 cycles after start.
    start_run(0, 1000, 1, 0);
    q_sig.push_back(100);
    q_ref.push_back(500);
    tick(1003);
    check("single_wait_valid", res_valid_o, 0);
    run_batch(1, 0);
    check("single_sig_100", res_sig_o, 100);
    check("single_ref_500", res_ref_o, 500);
    accept();
    check("single_idle_busy", busy_o, 0);
    check("single_idle_valid", res_valid_o, 0);

    // Average of four directed results.
    start_run(0, 50, 4, 0);
    for (int i = 0; i < 4; i++) begin
      q_sig.push_back(10 + i);
      q_ref.push_back(100);
    end
    run_batch(4, 5);
    check("avg4_sig_46", res_sig_o, 46);
    check("avg4_ref_400", res_ref_o, 400);
    accept();
    check("avg4_idle", busy_o, 0);

    // Random averages with full-range counts (exercises guard bits).
    for (int k = 0; k < 3; k++) begin
      n_avg = $urandom_range(2, 9);
      start_run(0, $urandom_range(1, 1000), n_avg, 0);
      push_random(n_avg);
      run_batch(n_avg, 3);
      accept();
      check("rand_avg_idle", busy_o, 0);
    end

    // Continuous, avg=0 (treated as 1), with backpressure on the first result.
    start_run(1, 20, 0, 0);
    push_random(1);
    run_batch(1, 2);
    held_sig = res_sig_o;
    held_ref = res_ref_o;
    bad_run  = 1'b0;
    bad_data = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) deliver($urandom, $urandom);
      else tick();
      if (meas_run_o !== 1'b0 || res_valid_o !== 1'b1) bad_run = 1'b1;
      if (res_sig_o !== held_sig || res_ref_o !== held_ref) bad_data = 1'b1;
    end
    check("stall_run_low", bad_run, 0);
    check("stall_data_stable", bad_data, 0);
    accept();
    check("cont_rearm_valid", res_valid_o, 0);
    check("cont_rearm_busy", busy_o, 1);
    tick();
    check("cont_rearm_run", meas_run_o, 1);
    check("cont_rearm_gate", meas_gate_time_o, 20);
    push_random(1);
    run_batch(1, 2);
    accept();
    tick();
    check("cont_third_run", meas_run_o, 1);
    cmd_stop_i = 1'b1;
    tick();
    cmd_stop_i = 1'b0;
    push_random(1);
    run_batch(1, 2);
    accept();
    check("stop_idle_busy", busy_o, 0);
    tick(3);
    check("stop_stays_idle", busy_o, 0);
    check("stop_run_low", meas_run_o, 0);

    // Timeout=200 with no result: fires in WAIT cycle 200.
    start_run(0, 30, 1, 200);
    seen_valid = 1'b0;
    bad_run    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (res_valid_o) seen_valid = 1'b1;
      if (timeout_o) bad_run = 1'b1;
    end
    check("tmo_not_early", bad_run, 0);
    check("tmo_busy_before", busy_o, 1);
    tick();
    check("tmo_set", timeout_o, 1);
    check("tmo_idle", busy_o, 0);
    check("tmo_run_low", meas_run_o, 0);
    tick(5);
    if (res_valid_o) seen_valid = 1'b1;
    check("tmo_sticky", timeout_o, 1);
    check("tmo_no_result", seen_valid, 0);

    // Result on exactly the timeout cycle wins.
    start_run(0, 30, 1, 200);
    tick(200);
    push_random(1);
    run_batch(1, 0);
    check("tmo_edge_no_timeout", timeout_o, 0);
    accept();

    // Mid-average result restarts the timeout; partial sum is discarded on timeout.
    start_run(0, 30, 2, 50);
    tick(40);
    deliver($urandom, $urandom);
    tick(50);
    check("tmo_restart_busy", busy_o, 1);
    check("tmo_restart_flag", timeout_o, 0);
    tick();
    check("tmo2_set", timeout_o, 1);
    check("tmo2_acc_discarded", res_sig_o, 0);

    // Start while busy is ignored; stop in single mode has no effect.
    start_run(0, 77, 1, 0);
    tick(3);
    cfg_gate_time_i = 5;
    cfg_avg_num_i   = 3;
    cmd_start_i     = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    cmd_stop_i  = 1'b1;
    tick();
    cmd_stop_i = 1'b0;
    check("busy_start_gate", meas_gate_time_o, 77);
    check("busy_start_run", meas_run_o, 1);
    push_random(1);
    run_batch(1, 2);
    accept();
    check("busy_start_idle", busy_o, 0);

    // Reset in WAIT returns everything to zero with no result.
    start_run(0, 99, 2, 0);
    deliver($urandom | 32'h1, $urandom | 32'h1);
    rst_i = 1'b1;
    tick();
    check("wrst_run", meas_run_o, 0);
    check("wrst_gate", meas_gate_time_o, 0);
    check("wrst_valid", res_valid_o, 0);
    check("wrst_sig", res_sig_o, 0);
    check("wrst_ref", res_ref_o, 0);
    check("wrst_busy", busy_o, 0);
    check("wrst_timeout", timeout_o, 0);
    rst_i = 1'b0;
    tick(2);
    deliver($urandom, $urandom);
    check("post_rst_valid", res_valid_o, 0);
    check("post_rst_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
